// File: rtl/gray_code_counter_pkg.sv
// Shared constants and the reference binary-to-Gray mapping.
// The function is also reused by the Gray decoder bench for cross-checking.
package gray_code_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Operates on a 32-bit container so that any code width up to 32 can use it.
    // Callers zero-extend their value and truncate the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_code_counter_bin_to_gray.sv
// Purpose: combinational binary-to-Gray mapping, WIDTH bits wide.
// Latency: 0 cycles; pure logic with no state.
// Backpressure: none; the output always follows the input.
module bin_to_gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// Purpose: loadable up/down binary counter with registered Gray output and wrap pulse.
// Latency: 1 clock from en/load to bin_out, gray_out and wrap; no input-to-output comb path.
// Backpressure: none; the counter steps on every en cycle and load overrides en.
module gray_code_counter
    import gray_code_counter_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_BIN = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(32'(RST_BIN)));

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;

    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;

    // Priority mux: load beats en, en beats hold; reset is applied in the register.
    always_comb begin
        bin_nxt  = bin_q;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_bin;
        end else if (en) begin
            if (up_dn) begin
                bin_nxt  = bin_q + ONE;
                wrap_nxt = &bin_q;
            end else begin
                bin_nxt  = bin_q - ONE;
                wrap_nxt = ~|bin_q;
            end
        end
    end

    // Gray is derived from the next binary value so both registers update on the same edge.
    bin_to_gray #(
        .WIDTH (WIDTH)
    ) u_bin_to_gray (
        .bin  (bin_nxt),
        .gray (gray_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_nxt;
            gray_q <= gray_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter: two instances (RST_BIN=0 and RST_BIN=5) share stimulus and are
// compared every cycle against an arithmetic model, with literal expectations for fixed scenarios.
module tb_gray_code_counter;
    import gray_code_counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_bin;

    logic [3:0] bin0, gray0, bin5, gray5;
    logic       wrap0, wrap5;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    int exp_bin0, exp_bin5;
    bit exp_wrap0, exp_wrap5;

    always #5 clk = ~clk;

    gray_code_counter #(.WIDTH(4), .RST_BIN(4'd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
        .bin_out(bin0), .gray_out(gray0), .wrap(wrap0)
    );

    gray_code_counter #(.WIDTH(4), .RST_BIN(4'd5)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_bin(load_bin),
        .bin_out(bin5), .gray_out(gray5), .wrap(wrap5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: count kept as a plain integer modulo 16.
    function automatic int step_bin(int b, bit ld, int lb, bit e, bit u);
        if (ld) return lb;
        if (!e) return b;
        return u ? (b + 1) % 16 : (b + 15) % 16;
    endfunction

    function automatic bit step_wrap(int b, bit ld, bit e, bit u);
        if (ld || !e) return 1'b0;
        return u ? (b == 15) : (b == 0);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_bin0  <= 0;
            exp_bin5  <= 5;
            exp_wrap0 <= 1'b0;
            exp_wrap5 <= 1'b0;
        end else begin
            exp_bin0  <= step_bin(exp_bin0, load, int'(load_bin), en, up_dn);
            exp_bin5  <= step_bin(exp_bin5, load, int'(load_bin), en, up_dn);
            exp_wrap0 <= step_wrap(exp_bin0, load, en, up_dn);
            exp_wrap5 <= step_wrap(exp_bin5, load, en, up_dn);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_bin0",  32'(bin0),  32'(exp_bin0));
            check("model_gray0", 32'(gray0), bin2gray(32'(exp_bin0)) & 32'hF);
            check("model_wrap0", 32'(wrap0), 32'(exp_wrap0));
            check("model_bin5",  32'(bin5),  32'(exp_bin5));
            check("model_gray5", 32'(gray5), bin2gray(32'(exp_bin5)) & 32'hF);
            check("model_wrap5", 32'(wrap5), 32'(exp_wrap5));
        end
    end

    int         gray_seq [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    logic [3:0] prev_gray;

    initial begin
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = 4'd0;

        // Reset held two clocks
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_bin0", 32'(bin0), 0);
        check("rst_gray0", 32'(gray0), 0);
        check("rst_wrap0", 32'(wrap0), 0);
        check("rst_bin5", 32'(bin5), 5);
        check("rst_gray5", 32'(gray5), 32'b0111);
        rst_n = 1'b1;
        @(negedge clk);
        check("hold_bin0", 32'(bin0), 0);
        check("hold_gray5", 32'(gray5), 32'b0111);

        // Full up-count cycle with wrap
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prev_gray = gray0;
            @(negedge clk);
            check("up_gray", 32'(gray0), 32'(gray_seq[i+1]));
            check("up_wrap", 32'(wrap0), (i == 15) ? 32'd1 : 32'd0);
            check("up_hamming", 32'($countones(gray0 ^ prev_gray)), 1);
        end
        en = 1'b0;

        // Load
        load = 1'b1; load_bin = 4'b1011;
        @(negedge clk);
        check("load11_bin", 32'(bin0), 11);
        check("load11_gray", 32'(gray0), 32'b1110);
        check("load11_wrap", 32'(wrap0), 0);
        load_bin = 4'b1111;
        @(negedge clk);
        check("load15_gray", 32'(gray0), 32'b1000);

        // Down wrap from zero
        load_bin = 4'd0;
        @(negedge clk);
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        @(negedge clk);
        check("dn_wrap_bin", 32'(bin0), 15);
        check("dn_wrap_gray", 32'(gray0), 32'b1000);
        check("dn_wrap_wrap", 32'(wrap0), 1);
        @(negedge clk);
        check("dn_bin", 32'(bin0), 14);
        check("dn_gray", 32'(gray0), 32'b1001);
        check("dn_wrap", 32'(wrap0), 0);

        // Conflicts
        load = 1'b1; load_bin = 4'd3; en = 1'b1; up_dn = 1'b1;
        @(negedge clk);
        check("load_over_en", 32'(bin0), 3);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_over_load", 32'(bin0), 0);
        check("rst_over_load5", 32'(bin5), 5);
        rst_n = 1'b1; load = 1'b0; en = 1'b1; up_dn = 1'b1;
        repeat (9) @(negedge clk);
        check("count9", 32'(bin0), 9);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_bin", 32'(bin0), 0);
        check("mid_rst_wrap", 32'(wrap0), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("resume_bin", 32'(bin0), 1);
        check("resume_gray", 32'(gray0), 1);

        // Random traffic
        for (int i = 0; i < 1000; i++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            load     = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 9) < 7);
            up_dn    = $urandom_range(0, 1) != 0;
            load_bin = 4'($urandom_range(0, 15));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
